// File: rtl/fft_pkg.sv
// Shared constants, sample type and element-mapping helper for the FFT
// column datapath.
package fft_pkg;

    localparam int W      = 64;                 // complex sample width
    localparam int NMAC   = 4;                  // MAC units per column
    localparam int PHASES = 4;                  // mac_sel phases per vector
    localparam int LANES  = NMAC * 2;           // lanes delivered per beat
    localparam int N      = NMAC * 2 * PHASES;  // vector length

    // Complex sample: real part in the upper half, imaginary in the lower.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    // Position of MAC m, output k, phase p within the assembled vector.
    function automatic int elem_idx(input int m, input int k, input int p);
        return m * 2 * PHASES + k * PHASES + p;
    endfunction

endpackage

// File: rtl/fft_vec_bank.sv
// One vector buffer: N complex samples held in flops. A beat writes the
// eight lanes of one phase; the whole vector is readable as a flat bus
// with element 0 in the MSBs.
module fft_vec_bank
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [1:0]         wr_phase,
    input  logic [LANES*W-1:0] wr_data,
    output logic [N*W-1:0]     rd_vec
);

    for (genvar m = 0; m < NMAC; m++) begin : g_mac
        for (genvar k = 0; k < 2; k++) begin : g_out
            for (genvar p = 0; p < PHASES; p++) begin : g_phase
                localparam int E = elem_idx(m, k, p);
                localparam int L = m * 2 + k;

                cplx_t elem_q;

                // Capture this lane when its phase is written; cleared on reset.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        elem_q <= '0;
                    end else if (we && (wr_phase == 2'(p))) begin
                        elem_q <= wr_data[L*W +: W];
                    end
                end

                assign rd_vec[N*W-1-E*W -: W] = elem_q;
            end
        end
    end

endmodule

// File: rtl/fft_col_collector.sv
// Collects the butterfly column's phase-multiplexed MAC results into a
// ping-pong pair of vector banks and hands complete vectors downstream.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is derived only from the bank-full flags (never
// from out_ready), and out_valid/out_vec come straight from flops, so no
// combinational path crosses the block. Once out_valid is raised the vector
// stays stable until it is taken.
module fft_col_collector
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [1:0]              in_phase,
    input  logic [NMAC*2*W-1:0]     in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*W-1:0]          out_vec,
    output logic                    err_seq
);

    logic [1:0]   full;
    logic         wr_bank;
    logic         rd_bank;
    logic [1:0]   exp_phase;

    logic         accept;
    logic         in_order;
    logic         resync;
    logic         do_write;
    logic         last_write;
    logic         out_fire;
    logic [N*W-1:0] rd_vec0;
    logic [N*W-1:0] rd_vec1;

    assign in_ready   = !full[wr_bank];
    assign out_valid  = full[rd_bank];
    assign accept     = in_valid && in_ready;
    assign in_order   = (in_phase == exp_phase);
    // A phase-0 beat always restarts the fill, even mid-vector.
    assign resync     = (in_phase == 2'd0) && (exp_phase != 2'd0);
    assign do_write   = accept && (in_order || resync);
    assign last_write = accept && in_order && (in_phase == 2'(PHASES - 1));
    assign out_fire   = out_valid && out_ready;

    // Bank ownership, phase tracking and the sticky sequencing error.
    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            exp_phase <= 2'd0;
            err_seq   <= 1'b0;
        end else begin
            // A write needs a free bank and a read needs a full one, so the
            // two updates below never target the same flag in one cycle.
            if (last_write) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (out_fire) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (accept) begin
                if (in_order) begin
                    exp_phase <= exp_phase + 2'd1;
                end else if (resync) begin
                    exp_phase <= 2'd1;
                    err_seq   <= 1'b1;
                end else begin
                    err_seq   <= 1'b1;
                end
            end
        end
    end

    fft_vec_bank u_bank0 (
        .clk      (clk),
        .reset    (reset),
        .we       (do_write && !wr_bank),
        .wr_phase (in_phase),
        .wr_data  (in_data),
        .rd_vec   (rd_vec0)
    );

    fft_vec_bank u_bank1 (
        .clk      (clk),
        .reset    (reset),
        .we       (do_write && wr_bank),
        .wr_phase (in_phase),
        .wr_data  (in_data),
        .rd_vec   (rd_vec1)
    );

    // Present the bank currently owned by the reader.
    always_comb begin
        out_vec = rd_bank ? rd_vec1 : rd_vec0;
    end

endmodule

// File: tb/tb_fft_col_collector.sv
// Directed bench for fft_col_collector: a driver issues phase beats, the
// expected vector is queued when its last beat is accepted, and a monitor
// compares every vector the DUT hands over.
module tb_fft_col_collector;
    import fft_pkg::*;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic [1:0]         in_phase;
    logic [LANES*W-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [N*W-1:0]     out_vec;
    logic               err_seq;

    logic [N*W-1:0] exp_q[$];
    int tests;
    int fails;

    fft_col_collector dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_phase  (in_phase),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .err_seq   (err_seq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [W-1:0] sample(input int v, input int m, input int k, input int p);
        logic [31:0] tag;
        tag = 32'hC000_0000 + 32'(m * 256 + k * 16 + p);
        return {32'(v), tag};
    endfunction

    function automatic logic [LANES*W-1:0] make_lanes(input int v, input int p);
        logic [LANES*W-1:0] d;
        d = '0;
        for (int m = 0; m < NMAC; m++)
            for (int k = 0; k < 2; k++)
                d[(m*2+k)*W +: W] = sample(v, m, k, p);
        return d;
    endfunction

    function automatic logic [N*W-1:0] make_vec(input int v);
        logic [N*W-1:0] d;
        d = '0;
        for (int m = 0; m < NMAC; m++)
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < PHASES; p++)
                    d[N*W-1-(m*8+k*4+p)*W -: W] = sample(v, m, k, p);
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until accepted; returns stall cycles.
    task automatic drive_beat(input int v, input int p, output int stalls);
        logic rdy;
        bit   done;
        done   = 0;
        stalls = 0;
        in_valid = 1'b1;
        in_phase = 2'(p);
        in_data  = make_lanes(v, p);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
            else stalls++;
        end
        in_valid = 1'b0;
        if (!done) check("beat_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_vec(input int v, input bit expect_out);
        int s;
        for (int p = 0; p < PHASES; p++) drive_beat(v, p, s);
        if (expect_out) exp_q.push_back(make_vec(v));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        int s;
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_phase  = 2'd0;
        in_data   = '0;
        out_ready = 1'b0;

        // Monitor: compare each vector taken by the consumer.
        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL vec_unexpected: got vector with nothing expected at %0t", $time);
                    end else begin
                        logic [N*W-1:0] ev;
                        ev = exp_q.pop_front();
                        if (out_vec !== ev) begin
                            int first;
                            first = -1;
                            for (int e = N - 1; e >= 0; e--)
                                if (out_vec[N*W-1-e*W -: W] !== ev[N*W-1-e*W -: W]) first = e;
                            fails++;
                            $display("FAIL vec_data: element %0d got %h expected %h at %0t",
                                     first, out_vec[N*W-1-first*W -: W], ev[N*W-1-first*W -: W], $time);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_err_seq",   64'(err_seq),   64'(0));
        check("rst_out_vec_zero", 64'(out_vec == '0), 64'(1));
        reset = 1'b0;

        // 1: single vector, consumer ready
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) drive_beat(1, p, s);
        check("s1_valid_before_last", 64'(out_valid), 64'(0));
        drive_beat(1, 3, s);
        exp_q.push_back(make_vec(1));
        check("s1_valid_after_last", 64'(out_valid), 64'(1));
        check("s1_err_seq", 64'(err_seq), 64'(0));
        idle(2);
        wait_drain();

        // 2: three vectors against a stalled consumer
        out_ready = 1'b0;
        send_vec(2, 1);
        send_vec(3, 1);
        check("s2_in_ready_both_full", 64'(in_ready), 64'(0));
        check("s2_out_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b1;
        in_phase = 2'd0;
        in_data  = make_lanes(4, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("s2_in_ready_held", 64'(in_ready), 64'(0));
        check("s2_ignored_not_err", 64'(err_seq), 64'(0));
        out_ready = 1'b1;
        send_vec(4, 1);
        wait_drain();

        // 3: continuous stream, one vector every four cycles
        for (int v = 5; v < 9; v++) begin
            for (int p = 0; p < PHASES; p++) begin
                drive_beat(v, p, s);
                check("s3_no_stall", 64'(s), 64'(0));
                check("s3_in_ready", 64'(in_ready), 64'(1));
                if (p == 3) begin
                    exp_q.push_back(make_vec(v));
                    check("s3_valid_on_last", 64'(out_valid), 64'(1));
                end else if (v > 5) begin
                    check("s3_valid_between", 64'(out_valid), 64'(0));
                end
            end
        end
        idle(2);
        wait_drain();

        // 6: bubbles between every beat
        for (int p = 0; p < PHASES; p++) begin
            drive_beat(9, p, s);
            if (p < 3) begin
                check("s6_no_valid_mid", 64'(out_valid), 64'(0));
                idle(1);
            end
        end
        exp_q.push_back(make_vec(9));
        check("s6_valid_after_last", 64'(out_valid), 64'(1));
        idle(2);
        wait_drain();
        check("s6_err_seq", 64'(err_seq), 64'(0));

        // 4: skipped phase, then resync on phase 0
        drive_beat(10, 0, s);
        drive_beat(10, 1, s);
        drive_beat(10, 3, s);
        check("s4_err_seq_set", 64'(err_seq), 64'(1));
        idle(3);
        check("s4_no_out_valid", 64'(out_valid), 64'(0));
        for (int p = 0; p < 3; p++) drive_beat(11, p, s);
        check("s4_no_valid_early", 64'(out_valid), 64'(0));
        drive_beat(11, 3, s);
        exp_q.push_back(make_vec(11));
        check("s4_resync_valid", 64'(out_valid), 64'(1));
        check("s4_err_sticky", 64'(err_seq), 64'(1));
        idle(2);
        wait_drain();

        // 5: reset with one vector pending and a partial fill
        out_ready = 1'b0;
        send_vec(12, 0);
        for (int p = 0; p < 3; p++) drive_beat(13, p, s);
        check("s5_pending_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s5_rst_out_valid", 64'(out_valid), 64'(0));
        check("s5_rst_in_ready",  64'(in_ready),  64'(1));
        check("s5_rst_out_vec_zero", 64'(out_vec == '0), 64'(1));
        check("s5_rst_err_seq",   64'(err_seq),   64'(0));
        reset = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) drive_beat(14, p, s);
        drive_beat(14, 3, s);
        exp_q.push_back(make_vec(14));
        check("s5_fresh_valid", 64'(out_valid), 64'(1));
        idle(2);
        wait_drain();
        check("s5_err_seq_clear", 64'(err_seq), 64'(0));

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
